// File: rtl/md_unit.sv
// md_unit: MIPS E-stage multiply/divide unit with HI/LO, busy counter and stall request.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [63:0]   pend_q, pend_d;
  logic          busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          is_mul, is_div, go, done, ovf;
  logic [63:0]   smul, umul, mul_res, div_res;
  logic [31:0]   squo, srem;
  assign smul = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign umul = {32'b0, A} * {32'b0, B};
  assign squo = $signed(A) / $signed(B);
  assign srem = $signed(A) % $signed(B);
  // The most-negative / -1 quotient overflows; force the architected result.
  assign ovf  = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
  always_comb begin
    is_mul  = (MDOp == 3'd1) || (MDOp == 3'd2);
    is_div  = (MDOp == 3'd3) || (MDOp == 3'd4);
    go      = !busy_q && start && (is_mul || is_div);
    done    = busy_q && (cnt_q == CW'(1));
    mul_res = (MDOp == 3'd1) ? smul : umul;
    div_res = (B == 32'b0) ? {hi_q, lo_q} :
              (MDOp == 3'd4) ? {A % B, A / B} :
              ovf ? {32'h0, 32'h8000_0000} : {srem, squo};
    pend_d  = go ? (is_mul ? mul_res : div_res) : pend_q;
    busy_d  = go || (busy_q && !done);
    cnt_d   = go ? (is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES)) :
              busy_q ? cnt_q - CW'(1) : '0;
    hi_d    = done ? pend_q[63:32] : (!busy_q && MDOp == 3'd5) ? A : hi_q;
    lo_d    = done ? pend_q[31:0]  : (!busy_q && MDOp == 3'd6) ? A : lo_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q   <= '0;
      lo_q   <= '0;
      pend_q <= '0;
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      pend_q <= pend_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end
  assign busy      = busy_q;
  assign stall_req = start | busy_q;
  assign HI        = hi_q;
  assign LO        = lo_q;
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed self-checking bench for md_unit.
module tb_md_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  MDOp = 3'd0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        busy, stall_req;
  logic [31:0] HI, LO;
  int tests = 0;
  int fails = 0;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .MDOp(MDOp), .A(A), .B(B),
    .busy(busy), .stall_req(stall_req), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic issue(input logic s, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = s; MDOp = op; A = a; B = b;
    @(posedge clk); #1;
    start = 1'b0; MDOp = 3'd0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
    tests++; if (stall_req !== 1'b0) begin fails++; $display("FAIL reset_stall got=%b exp=0", stall_req); end
    tests++; if (HI !== 32'h0 || LO !== 32'h0) begin fails++; $display("FAIL reset_hilo got=%h/%h exp=0/0", HI, LO); end
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic test_mult;
    @(negedge clk);
    start = 1'b1; MDOp = 3'd1; A = 32'hFFFF_FFFF; B = 32'd2;
    #1;
    tests++; if (stall_req !== 1'b1) begin fails++; $display("FAIL mult_stall_start got=%b exp=1", stall_req); end
    @(posedge clk); #1;
    start = 1'b0; MDOp = 3'd0;
    for (int i = 0; i < 5; i++) begin
      tests++; if (busy !== 1'b1 || stall_req !== 1'b1) begin fails++; $display("FAIL mult_busy cyc=%0d got=%b/%b exp=1/1", i, busy, stall_req); end
      @(posedge clk); #1;
    end
    tests++; if (busy !== 1'b0 || stall_req !== 1'b0) begin fails++; $display("FAIL mult_done_busy got=%b/%b exp=0/0", busy, stall_req); end
    tests++; if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFE) begin fails++; $display("FAIL mult_res got=%h/%h exp=ffffffff/fffffffe", HI, LO); end
  endtask

  task automatic test_multu;
    issue(1'b1, 3'd2, 32'hFFFF_FFFF, 32'd2);
    for (int i = 0; i < 5; i++) begin
      tests++; if (busy !== 1'b1 || HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFE) begin fails++; $display("FAIL multu_hold cyc=%0d got=%b %h/%h exp=1 ffffffff/fffffffe", i, busy, HI, LO); end
      @(posedge clk); #1;
    end
    tests++; if (busy !== 1'b0 || HI !== 32'h1 || LO !== 32'hFFFF_FFFE) begin fails++; $display("FAIL multu_res got=%b %h/%h exp=0 00000001/fffffffe", busy, HI, LO); end
  endtask

  task automatic test_div;
    issue(1'b1, 3'd3, 32'hFFFF_FFF9, 32'd2);
    for (int i = 0; i < 10; i++) begin
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL div_busy cyc=%0d got=%b exp=1", i, busy); end
      @(posedge clk); #1;
    end
    tests++; if (busy !== 1'b0 || HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFD) begin fails++; $display("FAIL div_res got=%b %h/%h exp=0 ffffffff/fffffffd", busy, HI, LO); end
    issue(1'b1, 3'd4, 32'd7, 32'd2);
    repeat (10) @(posedge clk);
    #1;
    tests++; if (busy !== 1'b0 || HI !== 32'd1 || LO !== 32'd3) begin fails++; $display("FAIL divu_res got=%b %h/%h exp=0 1/3", busy, HI, LO); end
    issue(1'b1, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    repeat (10) @(posedge clk);
    #1;
    tests++; if (HI !== 32'h0 || LO !== 32'h8000_0000) begin fails++; $display("FAIL div_ovf got=%h/%h exp=0/80000000", HI, LO); end
  endtask

  task automatic test_mthi_mtlo_divzero;
    issue(1'b0, 3'd5, 32'h11, 32'd0);
    tests++; if (HI !== 32'h11 || busy !== 1'b0) begin fails++; $display("FAIL mthi got=%h busy=%b exp=11 busy=0", HI, busy); end
    issue(1'b0, 3'd6, 32'h22, 32'd0);
    tests++; if (LO !== 32'h22 || HI !== 32'h11 || busy !== 1'b0) begin fails++; $display("FAIL mtlo got=%h/%h busy=%b exp=11/22 busy=0", HI, LO, busy); end
    issue(1'b1, 3'd7, 32'h99, 32'd3);
    issue(1'b0, 3'd1, 32'h99, 32'd3);
    tests++; if (busy !== 1'b0 || HI !== 32'h11 || LO !== 32'h22) begin fails++; $display("FAIL noop got=%b %h/%h exp=0 11/22", busy, HI, LO); end
    issue(1'b1, 3'd3, 32'd5, 32'd0);
    for (int i = 0; i < 10; i++) begin
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL divz_busy cyc=%0d got=%b exp=1", i, busy); end
      @(posedge clk); #1;
    end
    tests++; if (busy !== 1'b0 || HI !== 32'h11 || LO !== 32'h22) begin fails++; $display("FAIL divz_res got=%b %h/%h exp=0 11/22", busy, HI, LO); end
  endtask

  task automatic test_ignore_and_reset;
    issue(1'b1, 3'd1, 32'd3, 32'd4);
    @(posedge clk); #1;
    start = 1'b1; MDOp = 3'd3; A = 32'd100; B = 32'd7;
    @(posedge clk); #1;
    start = 1'b0; MDOp = 3'd5; A = 32'hDEAD;
    @(posedge clk); #1;
    MDOp = 3'd0;
    tests++; if (busy !== 1'b1 || HI !== 32'h11) begin fails++; $display("FAIL ign_mid got=%b %h exp=1 11", busy, HI); end
    @(posedge clk); #1;
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL ign_last got=%b exp=1", busy); end
    @(posedge clk); #1;
    tests++; if (busy !== 1'b0 || HI !== 32'h0 || LO !== 32'd12) begin fails++; $display("FAIL ign_res got=%b %h/%h exp=0 0/c", busy, HI, LO); end
    issue(1'b1, 3'd1, 32'd5, 32'd6);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    tests++; if (busy !== 1'b0 || HI !== 32'h0 || LO !== 32'h0) begin fails++; $display("FAIL async_rst got=%b %h/%h exp=0 0/0", busy, HI, LO); end
    @(negedge clk) reset = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    tests++; if (busy !== 1'b0 || HI !== 32'h0 || LO !== 32'h0) begin fails++; $display("FAIL rst_nowb got=%b %h/%h exp=0 0/0", busy, HI, LO); end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    start = 1'b1; MDOp = 3'd1; A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    MDOp = 3'd4; A = 32'd100; B = 32'd7;
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL b2b_t0 got=%b exp=1", busy); end
    for (int i = 1; i < 5; i++) begin
      @(posedge clk); #1;
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL b2b_mult cyc=%0d got=%b exp=1", i, busy); end
    end
    @(posedge clk); #1;
    tests++; if (busy !== 1'b0 || stall_req !== 1'b1 || HI !== 32'h0 || LO !== 32'h1) begin fails++; $display("FAIL b2b_t5 got=%b %b %h/%h exp=0 1 0/1", busy, stall_req, HI, LO); end
    @(posedge clk); #1;
    start = 1'b0; MDOp = 3'd0;
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL b2b_t6 got=%b exp=1", busy); end
    for (int i = 7; i < 16; i++) begin
      @(posedge clk); #1;
      tests++; if (busy !== 1'b1 || LO !== 32'h1) begin fails++; $display("FAIL b2b_divu cyc=%0d got=%b %h exp=1 1", i, busy, LO); end
    end
    @(posedge clk); #1;
    tests++; if (busy !== 1'b0 || HI !== 32'd2 || LO !== 32'd14) begin fails++; $display("FAIL b2b_res got=%b %h/%h exp=0 2/e", busy, HI, LO); end
  endtask

  initial begin
    test_reset;
    test_mult;
    test_multu;
    test_div;
    test_mthi_mtlo_divzero;
    test_ignore_and_reset;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
